// File: rtl/dropper_pkg.sv
// Shared game/lane state types, key codes and helpers for the multi-lane arrow dropper.
package dropper_pkg;

    typedef enum logic [1:0] {HALTED, RUN, DONE} game_state_t;
    typedef enum logic [1:0] {WAIT, FALL, HIT, MISS} lane_state_t;

    localparam logic [7:0] KEY_START = 8'h2c;
    localparam logic [7:0] KEY_ESC   = 8'h01;

    localparam logic [7:0] LANE_KEY [8] = '{
        8'h04, 8'h16, 8'h07, 8'h1a, 8'h0d, 8'h0e, 8'h0f, 8'h10
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dropper_lane.sv
// One falling-arrow lane: start delay, fall, key-edge hit window and miss line.
module dropper_lane
    import dropper_pkg::*;
#(
    parameter int unsigned LANE_IDX   = 0,
    parameter int unsigned Y_START    = 100,
    parameter int unsigned Y_MAX      = 400,
    parameter int unsigned HIT_LO     = 340,
    parameter int unsigned SPRITE_H   = 40,
    parameter int unsigned SPEED      = 1,
    parameter int unsigned BASE_DELAY = 160,
    parameter int unsigned DELAY_STEP = 40
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        clear,
    input  logic        step,
    input  logic [11:0] frame_cnt,
    input  logic [7:0]  keycode,
    input  logic [7:0]  keycode_second,
    output logic [9:0]  y,
    output logic        visible,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        resolved
);

    localparam logic [7:0]  KEY         = LANE_KEY[LANE_IDX];
    localparam int unsigned START_FRAME = BASE_DELAY + LANE_IDX * DELAY_STEP;

    lane_state_t state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic        visible_q, hit_q, hit_d, miss_q, miss_d, prev_q;
    logic        present, press;
    logic [10:0] bottom;

    always_comb begin
        present = (keycode == KEY) || (keycode_second == KEY);
        press   = present && !prev_q;
        bottom  = 11'(y_q) + 11'(SPRITE_H);
        state_d = state_q;
        y_d     = y_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        if (clear) begin
            state_d = WAIT;
            y_d     = 10'(Y_START);
        end else if (step) begin
            unique case (state_q)
                WAIT: begin
                    if (32'(frame_cnt) >= START_FRAME) state_d = FALL;
                end
                FALL: begin
                    // Miss line wins over a press on the same frame.
                    if (bottom >= 11'(Y_MAX)) begin
                        state_d = MISS;
                        miss_d  = 1'b1;
                    end else if (press && bottom >= 11'(HIT_LO)) begin
                        state_d = HIT;
                        hit_d   = 1'b1;
                    end else begin
                        y_d = y_q + 10'(SPEED);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q   <= WAIT;
            y_q       <= 10'(Y_START);
            visible_q <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            visible_q <= (state_d == FALL);
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            prev_q    <= present;
        end
    end

    assign y          = y_q;
    assign visible    = visible_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign resolved   = (state_q == HIT) || (state_q == MISS);

endmodule

// File: rtl/arrow_lane_dropper.sv
// Multi-lane arrow dropper: global round FSM, frame counter, score and per-lane instances.
// Optional combo/max_combo tracking is built when DROPPER_COMBO_EN is defined.
module arrow_lane_dropper
    import dropper_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned X_START    = 100,
    parameter int unsigned X_STEP     = 60,
    parameter int unsigned Y_START    = 100,
    parameter int unsigned Y_MAX      = 400,
    parameter int unsigned HIT_LO     = 340,
    parameter int unsigned SPRITE_H   = 40,
    parameter int unsigned SPEED      = 1,
    parameter int unsigned BASE_DELAY = 160,
    parameter int unsigned DELAY_STEP = 40
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [7:0]            keycode,
    input  logic [7:0]            keycode_second,
    output logic [LANES*10-1:0]   lane_x,
    output logic [LANES*10-1:0]   lane_y,
    output logic [LANES-1:0]      lane_visible,
    output logic [LANES-1:0]      hit_pulse,
    output logic [LANES-1:0]      miss_pulse,
    output logic [15:0]           score,
`ifdef DROPPER_COMBO_EN
    output logic [7:0]            combo,
    output logic [7:0]            max_combo,
`endif
    output logic                  done
);

    game_state_t      game_q, game_d;
    logic [11:0]      cnt_q, cnt_d;
    logic [15:0]      score_q, score_d;
    logic [16:0]      score_sum;
    logic             done_q;
    logic [LANES-1:0] resolved;
    logic [3:0]       hit_cnt;
    logic             key_start, key_esc, enter_run, clear, step;

    always_comb begin
        key_start = (keycode == KEY_START) || (keycode_second == KEY_START);
        key_esc   = (keycode == KEY_ESC) || (keycode_second == KEY_ESC);
        game_d    = game_q;
        unique case (game_q)
            HALTED:  if (key_start) game_d = RUN;
            RUN:     if (&resolved) game_d = DONE;
            DONE:    if (key_esc) game_d = HALTED;
            default: game_d = HALTED;
        endcase
        enter_run = (game_q == HALTED) && (game_d == RUN);
        // Lanes sit at their start position whenever the round is halted.
        clear     = (game_q == HALTED) || (game_d == HALTED);
        step      = (game_q == RUN);

        cnt_d = cnt_q;
        if (enter_run) cnt_d = '0;
        else if (step && cnt_q != 12'hFFF) cnt_d = cnt_q + 12'd1;

        hit_cnt   = popcount8(8'(hit_pulse));
        score_sum = {1'b0, score_q} + 17'(hit_cnt);
        score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (enter_run) score_d = '0;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            game_q  <= HALTED;
            cnt_q   <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
        end else begin
            game_q  <= game_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            done_q  <= (game_d == DONE);
        end
    end

    assign score = score_q;
    assign done  = done_q;

`ifdef DROPPER_COMBO_EN
    logic [7:0] combo_q, max_q, combo_inc;
    logic [8:0] combo_sum;

    always_comb begin
        combo_sum = {1'b0, combo_q} + 9'(hit_cnt);
        combo_inc = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end

    // Peak sees the hit increment even when a same-frame miss zeroes the combo.
    always_ff @(posedge frame_clk) begin
        if (Reset || enter_run) begin
            combo_q <= '0;
            max_q   <= '0;
        end else begin
            combo_q <= (|miss_pulse) ? 8'h00 : combo_inc;
            if (combo_inc > max_q) max_q <= combo_inc;
        end
    end

    assign combo     = combo_q;
    assign max_combo = max_q;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_x[i*10 +: 10] = 10'(X_START + i * X_STEP);

        dropper_lane #(
            .LANE_IDX   (i),
            .Y_START    (Y_START),
            .Y_MAX      (Y_MAX),
            .HIT_LO     (HIT_LO),
            .SPRITE_H   (SPRITE_H),
            .SPEED      (SPEED),
            .BASE_DELAY (BASE_DELAY),
            .DELAY_STEP (DELAY_STEP)
        ) u_lane (
            .frame_clk      (frame_clk),
            .Reset          (Reset),
            .clear          (clear),
            .step           (step),
            .frame_cnt      (cnt_q),
            .keycode        (keycode),
            .keycode_second (keycode_second),
            .y              (lane_y[i*10 +: 10]),
            .visible        (lane_visible[i]),
            .hit_pulse      (hit_pulse[i]),
            .miss_pulse     (miss_pulse[i]),
            .resolved       (resolved[i])
        );
    end

endmodule

// File: tb/tb_arrow_lane_dropper.sv
// Bench for arrow_lane_dropper: directed rounds plus random key traffic against a frame-level model.
module tb_arrow_lane_dropper;

    localparam int LANES = 4;
    localparam int Y_START = 100, Y_MAX = 400, HIT_LO = 340, SPRITE_H = 40, SPEED = 1;
    localparam int BASE_DELAY = 160, DELAY_STEP = 40;
    localparam int S_WAIT = 0, S_FALL = 1, S_HIT = 2, S_MISS = 3;
    localparam int G_HALT = 0, G_RUN = 1, G_DONE = 2;

    logic                  frame_clk = 1'b0;
    logic                  Reset;
    logic [7:0]            keycode, keycode_second;
    logic [LANES*10-1:0]   lane_x, lane_y;
    logic [LANES-1:0]      lane_visible, hit_pulse, miss_pulse;
    logic [15:0]           score;
    logic                  done;
`ifdef DROPPER_COMBO_EN
    logic [7:0]            combo, max_combo;
`endif

    arrow_lane_dropper #(.LANES(LANES)) dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .keycode_second (keycode_second),
        .lane_x         (lane_x),
        .lane_y         (lane_y),
        .lane_visible   (lane_visible),
        .hit_pulse      (hit_pulse),
        .miss_pulse     (miss_pulse),
        .score          (score),
`ifdef DROPPER_COMBO_EN
        .combo          (combo),
        .max_combo      (max_combo),
`endif
        .done           (done)
    );

    always #5 frame_clk = ~frame_clk;

    int total = 0, passed = 0, failed = 0;
    logic [7:0] tb_keys [4] = '{8'h04, 8'h16, 8'h07, 8'h1a};

    int m_game, m_cnt, m_score, m_combo, m_max;
    bit m_done;
    int m_ly [LANES];
    int m_ls [LANES];
    bit m_prev [LANES];
    bit m_hit [LANES];
    bit m_miss [LANES];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [7:0] k1, input logic [7:0] k2);
        int nxt, hits, inc, bottom;
        bit all_res, enter, clr, any_miss, present, press;
        if (rst) begin
            m_game = G_HALT; m_cnt = 0; m_score = 0; m_combo = 0; m_max = 0; m_done = 0;
            for (int i = 0; i < LANES; i++) begin
                m_ly[i] = Y_START; m_ls[i] = S_WAIT;
                m_prev[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
            end
            return;
        end
        all_res = 1;
        hits = 0;
        any_miss = 0;
        for (int i = 0; i < LANES; i++) begin
            if (m_ls[i] == S_WAIT || m_ls[i] == S_FALL) all_res = 0;
            hits += int'(m_hit[i]);
            any_miss |= m_miss[i];
        end
        nxt = m_game;
        if (m_game == G_HALT && (k1 == 8'h2c || k2 == 8'h2c)) nxt = G_RUN;
        else if (m_game == G_RUN && all_res) nxt = G_DONE;
        else if (m_game == G_DONE && (k1 == 8'h01 || k2 == 8'h01)) nxt = G_HALT;
        enter = (m_game == G_HALT && nxt == G_RUN);
        clr = (m_game == G_HALT || nxt == G_HALT);
        if (enter) begin
            m_score = 0; m_combo = 0; m_max = 0;
        end else begin
            m_score = (m_score + hits > 65535) ? 65535 : m_score + hits;
            inc = (m_combo + hits > 255) ? 255 : m_combo + hits;
            if (inc > m_max) m_max = inc;
            m_combo = any_miss ? 0 : inc;
        end
        for (int i = 0; i < LANES; i++) begin
            present = (k1 == tb_keys[i]) || (k2 == tb_keys[i]);
            press = present && !m_prev[i];
            m_prev[i] = present;
            m_hit[i] = 0;
            m_miss[i] = 0;
            if (clr) begin
                m_ls[i] = S_WAIT;
                m_ly[i] = Y_START;
            end else if (m_game == G_RUN) begin
                if (m_ls[i] == S_WAIT) begin
                    if (m_cnt >= BASE_DELAY + i * DELAY_STEP) m_ls[i] = S_FALL;
                end else if (m_ls[i] == S_FALL) begin
                    bottom = m_ly[i] + SPRITE_H;
                    if (bottom >= Y_MAX) begin
                        m_ls[i] = S_MISS; m_miss[i] = 1;
                    end else if (press && bottom >= HIT_LO) begin
                        m_ls[i] = S_HIT; m_hit[i] = 1;
                    end else begin
                        m_ly[i] += SPEED;
                    end
                end
            end
        end
        if (enter) m_cnt = 0;
        else if (m_game == G_RUN && m_cnt < 4095) m_cnt++;
        m_game = nxt;
        m_done = (nxt == G_DONE);
    endtask

    task automatic check_all();
        logic [LANES*10-1:0] ex, ey;
        logic [LANES-1:0] ev, eh, em;
        for (int i = 0; i < LANES; i++) begin
            ex[i*10 +: 10] = 10'(100 + 60 * i);
            ey[i*10 +: 10] = 10'(m_ly[i]);
            ev[i] = (m_ls[i] == S_FALL);
            eh[i] = m_hit[i];
            em[i] = m_miss[i];
        end
        chk("lane_x", lane_x, ex);
        chk("lane_y", lane_y, ey);
        chk("lane_visible", lane_visible, ev);
        chk("hit_pulse", hit_pulse, eh);
        chk("miss_pulse", miss_pulse, em);
        chk("score", score, m_score);
        chk("done", done, m_done);
`ifdef DROPPER_COMBO_EN
        chk("combo", combo, m_combo);
        chk("max_combo", max_combo, m_max);
`endif
    endtask

    task automatic step(input logic [7:0] k1, input logic [7:0] k2);
        keycode = k1;
        keycode_second = k2;
        @(posedge frame_clk);
        #1;
        model_edge(Reset, k1, k2);
        check_all();
    endtask

    function automatic logic [7:0] rnd_key();
        logic [7:0] k;
        do k = 8'($urandom_range(0, 255)); while (k == 8'h2c || k == 8'h01);
        return k;
    endfunction

    function automatic logic [7:0] game_key();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) return 8'h00;
        if (r < 9) return tb_keys[$urandom_range(0, LANES - 1)];
        return rnd_key();
    endfunction

    task automatic wait_bottom(input int ln, input int bot);
        int n;
        n = 0;
        while (!(m_ls[ln] == S_FALL && m_ly[ln] + SPRITE_H == bot) && n < 2000) begin
            step(8'h00, 8'h00);
            n++;
        end
        chk("wait_y", lane_y[ln*10 +: 10], bot - SPRITE_H);
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while (!m_done && n < 2000) begin
            step(8'h00, 8'h00);
            n++;
        end
        chk("round_done", done, 1);
    endtask

    initial begin
        Reset = 1'b1;
        keycode = 8'h00;
        keycode_second = 8'h00;
        repeat (2) step(8'h00, 8'h00);
        chk("rst_y", lane_y, {4{10'd100}});
        chk("rst_vis", lane_visible, 0);
        Reset = 1'b0;
        repeat (20) step(rnd_key(), rnd_key());

        // Round A: no keys, every lane misses at y = 360.
        step(8'h2c, 8'h00);
        run_to_done();
        chk("a_score", score, 0);
        chk("a_miss_y", lane_y, {4{10'd360}});
        repeat (5) step(rnd_key(), rnd_key());
        step(8'h01, 8'h00);
        chk("a_halt_done", done, 0);
        chk("a_halt_y", lane_y, {4{10'd100}});

        // Round B: dual-key hit on lanes 0/1, then a single hit on lane 3.
        step(8'h00, 8'h2c);
        repeat (3) step(8'h2c, 8'h00);
        wait_bottom(1, 345);
        step(8'h04, 8'h16);
        chk("dual_hit", hit_pulse, 4'b0011);
        step(8'h00, 8'h00);
        chk("dual_score", score, 2);
        chk("dual_pulse_end", hit_pulse, 0);
        wait_bottom(3, 350);
        step(8'h1a, 8'h00);
        chk("l3_hit", hit_pulse, 4'b1000);
        chk("l3_y", lane_y[39:30], 310);
        run_to_done();
        chk("b_score", score, 3);
        chk("l3_frozen", lane_y[39:30], 310);
        step(8'h00, 8'h01);

        // Round C: key held from before the window never scores.
        step(8'h2c, 8'h00);
        wait_bottom(3, 330);
        for (int n = 0; n < 200 && m_ls[3] == S_FALL; n++) step(8'h1a, 8'h00);
        chk("held_miss", miss_pulse[3], 1);
        chk("held_y", lane_y[39:30], 360);
        run_to_done();
        chk("c_score", score, 0);
        step(8'h01, 8'h00);

        // Round D: random key traffic.
        step(8'h2c, 8'h00);
        for (int n = 0; n < 2000 && !m_done; n++) step(game_key(), game_key());
        chk("d_done", done, 1);
        step(8'h01, 8'h00);

        // Round E: reset mid-fall, then a full round and escape.
        step(8'h2c, 8'h00);
        repeat (250) step(game_key(), game_key());
        Reset = 1'b1;
        step(8'h00, 8'h00);
        Reset = 1'b0;
        chk("mid_rst_y", lane_y, {4{10'd100}});
        chk("mid_rst_score", score, 0);
        chk("mid_rst_done", done, 0);
        step(8'h2c, 8'h00);
        run_to_done();
        step(8'h01, 8'h00);
        chk("esc_done", done, 0);
        step(8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
